dcache_dm: RTL and testbench
============================

Name: dcache_dm

Overview:
- Direct-mapped, write-back, write-allocate data cache between the riscv core's data port (ALUOut/WriteData/MemWrite in, ReadData/dhit out) and the backing data memory.
- Hits complete in the same cycle. Misses stall the core (dhit=0) while a dirty victim line is written back and the new line is refilled over a 128-bit line-wide memory handshake.
- Keeps saturating hit and miss counters for performance checks.

Parameters:
- LINES, 4, number of cache lines; power of two, at least 2.
- INDEX_W, $clog2(LINES), index width.
- Derived: TAG_W = 28-INDEX_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- MemRead  input  1  load request from core.
- MemWrite  input  1  store request from core.
- ByteD  input  1  1 = byte access, 0 = word access.
- ALUOut  input  32  byte address from core.
- WriteData  input  32  store data; byte stores use [7:0].
- ReadData  output  32  aligned word at {ALUOut[31:2],2'b00}; the core extracts bytes.
- dhit  output  1  1 = access done this cycle or no access pending; 0 = core must stall.
- mem_req  output  1  memory request; held until mem_ready.
- mem_we  output  1  1 = line write-back, 0 = line fetch.
- mem_addr  output  32  line-aligned address, [3:0]=0.
- mem_wdata  output  128  victim line data.
- mem_rdata  input  128  refill data, valid when mem_ready=1.
- mem_ready  input  1  one-cycle completion pulse from memory.
- hit_count  output  16  saturating count of hit accesses.
- miss_count  output  16  saturating count of miss accesses.

Behaviour:
- Address split:
  - tag = ALUOut[31:4+INDEX_W]
  - index = ALUOut[3+INDEX_W:4]
  - word = ALUOut[3:2]
  - byte = ALUOut[1:0]
- Per line: valid, dirty, tag, 4x32 data.
- States: COMPARE, WRITEBACK, REFILL. Reset state is COMPARE.
- Reset (reset==0 at a clk edge):
  - valid and dirty bits clear, state goes to COMPARE.
  - mem_req=0, mem_we=0, mem_addr=0, counters=0.
  - Data arrays are not cleared.
  - Reset in WRITEBACK or REFILL abandons the transfer. mem_req is low from the next cycle, dirty data is lost, and a late mem_ready is ignored.
- Access rules:
  - An access is MemRead|MemWrite. If both are 1, it is a store.
  - The core holds ALUOut, WriteData, ByteD and the request stable while dhit=0.
- COMPARE, no access:
  - dhit=1; ReadData reflects the indexed line's data (don't-care).
- COMPARE, hit (valid && tag match):
  - dhit=1 combinationally; ReadData = line word, combinational.
  - On a store, at the clk edge:
    - word access writes the full word;
    - byte access writes only lane byte with WriteData[7:0];
    - dirty is set.
  - hit_count increments.
- COMPARE, miss:
  - dhit=0; miss_count increments once per miss, on the COMPARE cycle that detects it.
  - valid&&dirty victim: go to WRITEBACK. Otherwise go to REFILL.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={victim tag,index,4'b0}, mem_wdata=victim line.
  - mem_ready=1: go to REFILL on the next edge.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={req tag,index,4'b0}.
  - mem_ready=1: line ← mem_rdata, tag ← req tag, valid=1, dirty=0, go to COMPARE.
- dhit is 0 in WRITEBACK and REFILL.
- Miss latency: the retry in COMPARE after the refill hits. A store is merged at that point.
  - Clean miss: dhit=1 exactly 1 cycle after the mem_ready edge.
- mem_ready is sampled only in WRITEBACK and REFILL; it is ignored in COMPARE.
- mem_req, mem_we and mem_addr are registered and glitch-free.
- Line word n is mem_rdata[32n+31:32n], little-endian.
- Counters saturate at 16'hFFFF.

Test Plan:
1. Reset low 2 cycles, then idle → dhit=1, mem_req=0, hit_count=0, miss_count=0.
2. Word load 0x100, memory returns line {0x44444444,0x33333333,0x22222222,0x11111111} after 3 cycles → mem_req=1, mem_we=0, mem_addr=0x100. dhit=1 and ReadData=0x11111111 the cycle after mem_ready. miss_count=1.
3. Word store 0xDEADBEEF to 0x104, then load 0x104 → both hit with dhit=1 same cycle, ReadData=0xDEADBEEF, hit_count+=2, no mem_req.
4. With word 0x100 = 0x11223344, byte store WriteData=0x000000AB to 0x103, then word load 0x100 → ReadData=0xAB223344.
5. Dirty line 0x100 (LINES=4), load 0x140 → write-back with mem_we=1, mem_addr=0x100, mem_wdata holding the modified data. Then refill with mem_addr=0x140 and dhit=1 after. A reload of 0x100 misses.
6. Reset driven low mid-REFILL, then mem_ready pulsed → mem_req=0 next cycle, the late mem_ready has no effect, and a load of the same address misses again.

Source files
------------

// File: rtl/dcache_dm.sv
// -----------------------------------------------------------------------------
// dcache_dm -- direct-mapped, write-back, write-allocate data cache.
//
// Sits between the core data port and a line-wide (128-bit) backing memory.
// Hits complete combinationally in the same cycle. A miss stalls the core
// (dhit=0) while a dirty victim is written back and the requested line is
// refilled. The access is then retried in COMPARE, where it hits; a pending
// store is merged into the line at that point.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   MemRead, MemWrite   core request (both high = store)
//   ByteD               1 = byte access, 0 = word access
//   ALUOut              byte address from the core
//   WriteData           store data (byte stores use [7:0])
//   ReadData            aligned word at {ALUOut[31:2],2'b00}
//   dhit                1 = access done / idle, 0 = stall
//   mem_req/mem_we      registered memory request / 1 = write-back
//   mem_addr            registered line-aligned memory address
//   mem_wdata           victim line for write-back
//   mem_rdata/mem_ready refill data and one-cycle completion pulse
//   hit_count           saturating count of hit accesses
//   miss_count          saturating count of miss accesses
// -----------------------------------------------------------------------------
module dcache_dm #(
  parameter int LINES   = 4,
  parameter int INDEX_W = $clog2(LINES)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic         ByteD,
  input  logic [31:0]  ALUOut,
  input  logic [31:0]  WriteData,
  output logic [31:0]  ReadData,
  output logic         dhit,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int TAG_W = 28 - INDEX_W;

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } state_t;

  // Merge a word or single-byte store into a 128-bit line.
  function automatic logic [127:0] merge_store(
    input logic [127:0] line,
    input logic [1:0]   word,
    input logic [1:0]   lane,
    input logic         byte_acc,
    input logic [31:0]  wdata
  );
    logic [127:0] res;
    res = line;
    if (byte_acc) begin
      res[{word, lane, 3'b000} +: 8] = wdata[7:0];
    end else begin
      res[{word, 5'b00000} +: 32] = wdata;
    end
    return res;
  endfunction

  // State and storage
  state_t             state_q, state_d;
  logic               valid_q [LINES];
  logic               valid_d [LINES];
  logic               dirty_q [LINES];
  logic               dirty_d [LINES];
  logic [TAG_W-1:0]   tag_q   [LINES];
  logic [TAG_W-1:0]   tag_d   [LINES];
  logic [127:0]       line_q  [LINES];
  logic [127:0]       line_d  [LINES];

  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [15:0]        hit_count_q, hit_count_d;
  logic [15:0]        miss_count_q, miss_count_d;

  // Address split
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [1:0]         req_word;
  logic [1:0]         req_byte;

  assign req_tag  = ALUOut[31:4+INDEX_W];
  assign req_idx  = ALUOut[3+INDEX_W:4];
  assign req_word = ALUOut[3:2];
  assign req_byte = ALUOut[1:0];

  // Lookup of the indexed line
  logic               access;
  logic               in_compare;
  logic               tag_match;
  logic               hit;
  logic               miss;
  logic [127:0]       cur_line;
  logic [TAG_W-1:0]   cur_tag;

  assign access     = MemRead | MemWrite;
  assign in_compare = (state_q == S_COMPARE);
  assign cur_line   = line_q[req_idx];
  assign cur_tag    = tag_q[req_idx];
  assign tag_match  = valid_q[req_idx] && (cur_tag == req_tag);
  assign hit        = in_compare && access && tag_match;
  assign miss       = in_compare && access && !tag_match;

  assign ReadData   = cur_line[{req_word, 5'b00000} +: 32];
  assign dhit       = in_compare && (!access || tag_match);
  // The victim line stays untouched until the refill lands, so it can be
  // driven straight from the array during WRITEBACK.
  assign mem_wdata  = cur_line;

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Next-state, array update and counter logic
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    line_d       = line_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;

    case (state_q)
      S_COMPARE: begin
        if (hit) begin
          if (MemWrite) begin
            line_d[req_idx]  = merge_store(cur_line, req_word, req_byte, ByteD, WriteData);
            dirty_d[req_idx] = 1'b1;
          end else begin
            dirty_d[req_idx] = dirty_q[req_idx];
          end
          if (hit_count_q != 16'hFFFF) begin
            hit_count_d = hit_count_q + 16'd1;
          end else begin
            hit_count_d = hit_count_q;
          end
        end else if (miss) begin
          if (miss_count_q != 16'hFFFF) begin
            miss_count_d = miss_count_q + 16'd1;
          end else begin
            miss_count_d = miss_count_q;
          end
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_REFILL;
          end
        end else begin
          state_d = S_COMPARE;
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          state_d = S_REFILL;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_REFILL: begin
        if (mem_ready) begin
          line_d[req_idx]  = mem_rdata;
          tag_d[req_idx]   = req_tag;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          state_d          = S_COMPARE;
        end else begin
          state_d = S_REFILL;
        end
      end
      default: begin
        state_d = S_COMPARE;
      end
    endcase
  end

  // Memory interface registers follow the state being entered, so they are
  // valid for the whole WRITEBACK/REFILL stay and drop on return to COMPARE.
  always_comb begin
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = 32'h0000_0000;
    case (state_d)
      S_WRITEBACK: begin
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = {cur_tag, req_idx, 4'b0000};
      end
      S_REFILL: begin
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = {req_tag, req_idx, 4'b0000};
      end
      default: begin
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = 32'h0000_0000;
      end
    endcase
  end

  // Control state, line status bits, memory request and counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_COMPARE;
      valid_q      <= '{default: 1'b0};
      dirty_q      <= '{default: 1'b0};
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      hit_count_q  <= 16'h0000;
      miss_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data arrays: not cleared by reset, but frozen while it is held
  // so an abandoned refill never lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q  <= tag_d;
      line_q <= line_d;
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// -----------------------------------------------------------------------------
// tb_dcache_dm -- self-checking bench for dcache_dm (LINES=4).
// Expected read data and expected memory transactions are queued when an
// access is issued; read data is popped when dhit completes the access and
// memory transactions are popped by the memory responder when it answers.
// -----------------------------------------------------------------------------
module tb_dcache_dm;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         MemRead = 1'b0;
  logic         MemWrite = 1'b0;
  logic         ByteD = 1'b0;
  logic [31:0]  ALUOut = 32'h0;
  logic [31:0]  WriteData = 32'h0;
  logic [31:0]  ReadData;
  logic         dhit;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = 128'h0;
  logic         mem_ready = 1'b0;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  dcache_dm #(.LINES(4)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .ByteD(ByteD), .ALUOut(ALUOut), .WriteData(WriteData),
    .ReadData(ReadData), .dhit(dhit), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  txn_t         exp_txn_q [$];
  logic [31:0]  exp_rd_q [$];
  logic [127:0] mem_model [logic [27:0]];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic auto_mem   = 1'b1;
  logic late_pulse = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_txn(input logic we, input logic [31:0] addr, input logic [127:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    exp_txn_q.push_back(t);
  endtask

  // Issue one access, wait (bounded) for dhit, check read data, release.
  task automatic access(input logic st, input logic bt, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, output int lat);
    logic [31:0] e;
    @(negedge clk);
    MemRead = !st; MemWrite = st; ByteD = bt; ALUOut = addr; WriteData = wd;
    if (!st) exp_rd_q.push_back(exp_rd);
    lat = 0;
    #1;
    while (!dhit && lat < 60) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("dhit_wait", 128'(dhit), 128'd1);
    if (!st) begin
      e = exp_rd_q.pop_front();
      chk("ReadData", 128'(ReadData), 128'(e));
    end
    @(posedge clk);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; ByteD = 1'b0;
  endtask

  // Memory responder: answers each request 3 cycles after it appears and
  // checks it against the expected-transaction queue.
  int wait_cnt = 0;
  initial begin
    txn_t t;
    logic [27:0] k;
    forever begin
      @(negedge clk);
      if (late_pulse) begin
        mem_ready  = 1'b1;
        mem_rdata  = {4{32'hBADC0FFE}};
        late_pulse = 1'b0;
      end else if (auto_mem && mem_req && !mem_ready) begin
        if (wait_cnt == 2) begin
          wait_cnt  = 0;
          mem_ready = 1'b1;
          k = mem_addr[31:4];
          chk("txn_expected", 128'(exp_txn_q.size() > 0), 128'd1);
          if (exp_txn_q.size() > 0) begin
            t = exp_txn_q.pop_front();
            chk("mem_we", 128'(mem_we), 128'(t.we));
            chk("mem_addr", 128'(mem_addr), 128'(t.addr));
            if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
          end
          if (mem_we) begin
            mem_model[k] = mem_wdata;
          end else begin
            mem_rdata = mem_model.exists(k) ? mem_model[k] : {4{mem_addr}};
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  initial begin
    int lat;
    mem_model[28'h010] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    mem_model[28'h014] = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
    mem_model[28'h020] = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA, 32'h99999999};

    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_dhit", 128'(dhit), 128'd1);
    chk("rst_mem_req", 128'(mem_req), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    chk("rst_hit_count", 128'(hit_count), 128'd0);
    chk("rst_miss_count", 128'(miss_count), 128'd0);

    // 2: clean miss, refill, retry hits one cycle after mem_ready
    push_txn(1'b0, 32'h100, 128'h0);
    access(1'b0, 1'b0, 32'h100, 32'h0, 32'h11111111, lat);
    chk("t2_latency", 128'(lat), 128'd4);
    chk("t2_miss_count", 128'(miss_count), 128'd1);
    chk("t2_hit_count", 128'(hit_count), 128'd1);

    // 3: store hit then load hit
    access(1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0, lat);
    chk("t3_store_lat", 128'(lat), 128'd0);
    access(1'b0, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, lat);
    chk("t3_load_lat", 128'(lat), 128'd0);
    chk("t3_hit_count", 128'(hit_count), 128'd3);
    chk("t3_mem_req", 128'(mem_req), 128'd0);

    // 4: byte store into lane 3 uses only WriteData[7:0]
    access(1'b1, 1'b0, 32'h100, 32'h11223344, 32'h0, lat);
    access(1'b1, 1'b1, 32'h103, 32'h123456AB, 32'h0, lat);
    access(1'b0, 1'b0, 32'h100, 32'h0, 32'hAB223344, lat);
    chk("t4_hit_count", 128'(hit_count), 128'd6);

    // 5: dirty victim written back, then refill of the conflicting line
    push_txn(1'b1, 32'h100, {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'hAB223344});
    push_txn(1'b0, 32'h140, 128'h0);
    access(1'b0, 1'b0, 32'h140, 32'h0, 32'h55555555, lat);
    chk("t5_wb_latency", 128'(lat), 128'd8);
    push_txn(1'b0, 32'h100, 128'h0);
    access(1'b0, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, lat);
    chk("t5_reload_latency", 128'(lat), 128'd4);
    chk("t5_miss_count", 128'(miss_count), 128'd3);
    chk("t5_hit_count", 128'(hit_count), 128'd8);

    // 6: reset mid-refill, late mem_ready ignored
    auto_mem = 1'b0;
    @(negedge clk);
    MemRead = 1'b1; ALUOut = 32'h200;
    @(negedge clk);
    #1;
    chk("t6_req", 128'(mem_req), 128'd1);
    chk("t6_addr", 128'(mem_addr), 128'h200);
    chk("t6_we", 128'(mem_we), 128'd0);
    @(negedge clk);
    reset = 1'b0; MemRead = 1'b0;
    @(posedge clk);
    #1;
    late_pulse = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_req_dropped", 128'(mem_req), 128'd0);
    chk("t6_dhit_idle", 128'(dhit), 128'd1);
    chk("t6_miss_cleared", 128'(miss_count), 128'd0);
    @(negedge clk);
    #1;
    chk("t6_late_ready_req", 128'(mem_req), 128'd0);
    auto_mem = 1'b1;
    push_txn(1'b0, 32'h200, 128'h0);
    access(1'b0, 1'b0, 32'h200, 32'h0, 32'h99999999, lat);
    chk("t6_remiss_latency", 128'(lat), 128'd4);
    chk("t6_miss_count", 128'(miss_count), 128'd1);
    chk("t6_hit_count", 128'(hit_count), 128'd1);

    chk("txn_queue_empty", 128'(exp_txn_q.size()), 128'd0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
